aha_tlx_fwd_credit_mux: RTL and testbench

Multi-channel forward-link arbiter for the TLX bridge. It merges NUM_CH independent AXI-stream source channels onto the single TLX forward payload link. Each channel has its own credit counter, which is replenished by credit-return beats arriving on the forward flow channel. The block sits between the slave interface block's per-channel packetisers and the TLX forward physical layer. It generalises the previous fixed single-channel forward path to N virtual channels with credit-gated round-robin arbitration.

---
 rtl/aha_tlx_fwd_credit_mux.sv | 144 ++++++++++++++
 tb/tb_aha_tlx_fwd_credit_mux.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aha_tlx_fwd_credit_mux.sv
// Credit-gated round-robin merge of NUM_CH AXI-stream source channels onto the
// single TLX forward payload link; credits are replenished by flow-channel beats.
module aha_tlx_fwd_credit_mux #(
    parameter int NUM_CH     = 4,
    parameter int CH_ID_W    = 2,
    parameter int DATA_W     = 40,
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 8
) (
    input  logic                         TLX_FWD_CLK,
    input  logic                         TLX_FWD_RESETn,
    input  logic [NUM_CH-1:0]            TLX_CH_TVALID,
    output logic [NUM_CH-1:0]            TLX_CH_TREADY,
    input  logic [NUM_CH*DATA_W-1:0]     TLX_CH_TDATA,
    output logic                         TLX_FWD_PAYLOAD_TVALID,
    input  logic                         TLX_FWD_PAYLOAD_TREADY,
    output logic [CH_ID_W+DATA_W-1:0]    TLX_FWD_PAYLOAD_TDATA,
    input  logic                         TLX_FWD_FLOW_TVALID,
    output logic                         TLX_FWD_FLOW_TREADY,
    input  logic [CH_ID_W-1:0]           TLX_FWD_FLOW_TDATA,
    output logic [NUM_CH*CREDIT_W-1:0]   TLX_CREDIT_CNT,
    output logic                         TLX_CREDIT_ERR
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);
    localparam logic [CH_ID_W-1:0]  PTR_INIT   = CH_ID_W'(NUM_CH - 1);
    localparam logic [CH_ID_W:0]    NUM_CH_EXT = (CH_ID_W + 1)'(NUM_CH);

    logic                        active;
    logic [CREDIT_W-1:0]         credit [NUM_CH];
    logic [CH_ID_W-1:0]          ptr;
    logic                        out_vld;
    logic [CH_ID_W+DATA_W-1:0]   out_data;
    logic                        err;

    logic [NUM_CH-1:0]           eligible;
    logic [DATA_W-1:0]           ch_data [NUM_CH];
    logic [CH_ID_W-1:0]          cand;
    logic                        grant_vld;
    logic [CH_ID_W-1:0]          grant_id;
    logic [DATA_W-1:0]           grant_data;
    logic                        load_en;
    logic                        grant_fire;
    logic                        flow_fire;
    logic                        flow_id_ok;
    logic [NUM_CH-1:0]           dec_vec;
    logic [NUM_CH-1:0]           inc_vec;
    logic [NUM_CH-1:0]           ovf_vec;

    // Ready/credit traffic is only accepted from the first clock after reset release.
    always_ff @(posedge TLX_FWD_CLK or negedge TLX_FWD_RESETn) begin
        if (!TLX_FWD_RESETn) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_data[i]  = TLX_CH_TDATA[i*DATA_W +: DATA_W];
        assign eligible[i] = TLX_CH_TVALID[i] && (credit[i] != '0);
        assign TLX_CREDIT_CNT[i*CREDIT_W +: CREDIT_W] = credit[i];
    end

    assign load_en    = !out_vld || TLX_FWD_PAYLOAD_TREADY;
    assign grant_fire = active && grant_vld && load_en;
    assign flow_fire  = active && TLX_FWD_FLOW_TVALID;
    assign flow_id_ok = {1'b0, TLX_FWD_FLOW_TDATA} < NUM_CH_EXT;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        cand       = '0;
        grant_vld  = 1'b0;
        grant_id   = '0;
        grant_data = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_ID_W'((int'(ptr) + k) % NUM_CH);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_vld && eligible[i] && (cand == CH_ID_W'(i))) begin
                    grant_vld  = 1'b1;
                    grant_id   = cand;
                    grant_data = ch_data[i];
                end
            end
        end
    end

    always_comb begin
        TLX_CH_TREADY = '0;
        dec_vec       = '0;
        inc_vec       = '0;
        ovf_vec       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            TLX_CH_TREADY[i] = grant_fire && (grant_id == CH_ID_W'(i));
            dec_vec[i]       = grant_fire && (grant_id == CH_ID_W'(i));
            inc_vec[i]       = flow_fire && flow_id_ok && (TLX_FWD_FLOW_TDATA == CH_ID_W'(i));
            ovf_vec[i]       = inc_vec[i] && !dec_vec[i] && (credit[i] == CREDIT_MAX);
        end
    end

    // A same-cycle return and grant on one channel cancel; a return at full credit is dropped.
    always_ff @(posedge TLX_FWD_CLK or negedge TLX_FWD_RESETn) begin
        if (!TLX_FWD_RESETn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                credit[i] <= CREDIT_MAX;
            end
            err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (inc_vec[i] && !dec_vec[i] && !ovf_vec[i]) begin
                    credit[i] <= credit[i] + CREDIT_ONE;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    credit[i] <= credit[i] - CREDIT_ONE;
                end
            end
            if (flow_fire && (!flow_id_ok || (|ovf_vec))) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge TLX_FWD_CLK or negedge TLX_FWD_RESETn) begin
        if (!TLX_FWD_RESETn) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            ptr      <= PTR_INIT;
        end else begin
            if (load_en) begin
                out_vld <= grant_fire;
            end
            if (grant_fire) begin
                out_data <= {grant_id, grant_data};
                ptr      <= grant_id;
            end
        end
    end

    assign TLX_FWD_PAYLOAD_TVALID = out_vld;
    assign TLX_FWD_PAYLOAD_TDATA  = out_data;
    assign TLX_FWD_FLOW_TREADY    = active;
    assign TLX_CREDIT_ERR         = err;

endmodule

// File: tb/tb_aha_tlx_fwd_credit_mux.sv
// Directed bench for aha_tlx_fwd_credit_mux: a queue/arithmetic reference model is
// checked every cycle, plus literal expectations for the scenarios of interest.
module tb_aha_tlx_fwd_credit_mux;

    localparam int NCH  = 4;
    localparam int IDW  = 2;
    localparam int DW   = 40;
    localparam int CW   = 4;
    localparam int MAXC = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NCH-1:0]      ch_tvalid;
    logic [NCH-1:0]      ch_tready;
    logic [NCH*DW-1:0]   ch_tdata;
    logic                pvalid;
    logic                p_tready;
    logic [IDW+DW-1:0]   pdata;
    logic                flow_tvalid;
    logic                flow_tready;
    logic [IDW-1:0]      flow_tdata;
    logic [NCH*CW-1:0]   credit_cnt;
    logic                credit_err;

    logic [2:0]          d3_tready;
    logic                d3_pvalid;
    logic [IDW+DW-1:0]   d3_pdata;
    logic                d3_flow_tvalid;
    logic                d3_flow_tready;
    logic [IDW-1:0]      d3_flow_tdata;
    logic [3*CW-1:0]     d3_credit_cnt;
    logic                d3_credit_err;

    logic [DW-1:0]       chd [NCH];
    int                  seq [NCH];

    int                  m_cred [NCH];
    int                  m_last;
    bit                  m_ovld;
    logic [IDW+DW-1:0]   m_odata;
    bit                  m_err;
    bit                  m_active;
    bit                  m_fired;
    int                  m_fire_ch;

    int                  n_vec;
    int                  n_fail;
    bit                  cmp_en;
    int                  beats;
    int                  ids [$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NCH; i++) begin : g_data
        assign ch_tdata[i*DW +: DW] = chd[i];
    end

    aha_tlx_fwd_credit_mux #(
        .NUM_CH(NCH), .CH_ID_W(IDW), .DATA_W(DW), .CREDIT_W(CW), .MAX_CREDIT(MAXC)
    ) dut (
        .TLX_FWD_CLK           (clk),
        .TLX_FWD_RESETn        (rst_n),
        .TLX_CH_TVALID         (ch_tvalid),
        .TLX_CH_TREADY         (ch_tready),
        .TLX_CH_TDATA          (ch_tdata),
        .TLX_FWD_PAYLOAD_TVALID(pvalid),
        .TLX_FWD_PAYLOAD_TREADY(p_tready),
        .TLX_FWD_PAYLOAD_TDATA (pdata),
        .TLX_FWD_FLOW_TVALID   (flow_tvalid),
        .TLX_FWD_FLOW_TREADY   (flow_tready),
        .TLX_FWD_FLOW_TDATA    (flow_tdata),
        .TLX_CREDIT_CNT        (credit_cnt),
        .TLX_CREDIT_ERR        (credit_err)
    );

    // Three-channel variant so that an out-of-range flow ID can be presented.
    aha_tlx_fwd_credit_mux #(
        .NUM_CH(3), .CH_ID_W(IDW), .DATA_W(DW), .CREDIT_W(CW), .MAX_CREDIT(MAXC)
    ) dut3 (
        .TLX_FWD_CLK           (clk),
        .TLX_FWD_RESETn        (rst_n),
        .TLX_CH_TVALID         (3'b000),
        .TLX_CH_TREADY         (d3_tready),
        .TLX_CH_TDATA          ({(3*DW){1'b0}}),
        .TLX_FWD_PAYLOAD_TVALID(d3_pvalid),
        .TLX_FWD_PAYLOAD_TREADY(1'b1),
        .TLX_FWD_PAYLOAD_TDATA (d3_pdata),
        .TLX_FWD_FLOW_TVALID   (d3_flow_tvalid),
        .TLX_FWD_FLOW_TREADY   (d3_flow_tready),
        .TLX_FWD_FLOW_TDATA    (d3_flow_tdata),
        .TLX_CREDIT_CNT        (d3_credit_cnt),
        .TLX_CREDIT_ERR        (d3_credit_err)
    );

    function automatic logic [DW-1:0] mkdata(int c, int s);
        return {4'hC, 4'(c), 32'(s) ^ 32'h5A5A_0000};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) m_cred[c] = MAXC;
        m_last    = NCH - 1;
        m_ovld    = 1'b0;
        m_odata   = '0;
        m_err     = 1'b0;
        m_active  = 1'b0;
        m_fired   = 1'b0;
        m_fire_ch = 0;
    endtask

    // Channel picked by the rotating-priority rule, or -1 when nobody may go.
    function automatic int pick_grant();
        for (int n = 1; n <= NCH; n++) begin
            int c;
            c = (m_last + n) % NCH;
            if (((ch_tvalid >> c) & 4'b1) != 0 && m_cred[c] > 0) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int  g;
            int  id;
            bit  load;
            bit  fire;
            int  nc [NCH];
            load = !m_ovld || p_tready;
            g    = pick_grant();
            fire = m_active && (g >= 0) && load;
            nc   = m_cred;
            if (fire) nc[g] = nc[g] - 1;
            if (m_active && flow_tvalid) begin
                id = int'(flow_tdata);
                if (id >= NCH) m_err = 1'b1;
                else if (m_cred[id] == MAXC && !(fire && g == id)) m_err = 1'b1;
                else nc[id] = nc[id] + 1;
            end
            if (load) begin
                m_ovld = fire;
                if (fire) m_odata = {2'(g), chd[g]};
            end
            m_cred    = nc;
            m_fired   = fire;
            m_fire_ch = g;
            if (fire) m_last = g;
            m_active = 1'b1;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            int             g;
            logic [NCH-1:0] etr;
            logic [15:0]    ecred;
            g   = pick_grant();
            etr = '0;
            if (m_active && g >= 0 && (!m_ovld || p_tready)) etr = 4'(1 << g);
            for (int c = 0; c < NCH; c++) ecred[c*CW +: CW] = 4'(m_cred[c]);
            check_output("ch_tready", 64'(ch_tready), 64'(etr));
            check_output("payload_tvalid", 64'(pvalid), 64'(m_ovld));
            if (m_ovld) check_output("payload_tdata", 64'(pdata), 64'(m_odata));
            check_output("credit_cnt", 64'(credit_cnt), 64'(ecred));
            check_output("credit_err", 64'(credit_err), 64'(m_err));
            check_output("flow_tready", 64'(flow_tready), 64'(m_active));
            if (pvalid && p_tready) begin
                beats++;
                ids.push_back(int'(pdata[IDW+DW-1:DW]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (m_fired) begin
            seq[m_fire_ch]++;
            chd[m_fire_ch] = mkdata(m_fire_ch, seq[m_fire_ch]);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_output("reset_pvalid", 64'(pvalid), 64'd0);
        check_output("reset_credit", 64'(credit_cnt), 64'h8888);
        check_output("reset_tready", 64'(ch_tready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_rr_ids(input string name, input int n);
        check_output({name, "_count"}, 64'(ids.size()), 64'(n));
        for (int i = 0; i < ids.size() && i < n; i++) begin
            check_output(name, 64'(ids[i]), 64'(i % NCH));
        end
    endtask

    initial begin
        model_reset();
        n_vec = 0; n_fail = 0; cmp_en = 1'b0; beats = 0;
        rst_n = 1'b0;
        ch_tvalid = '0; p_tready = 1'b1; flow_tvalid = 1'b0; flow_tdata = '0;
        d3_flow_tvalid = 1'b0; d3_flow_tdata = '0;
        for (int c = 0; c < NCH; c++) begin
            seq[c] = 0;
            chd[c] = mkdata(c, 0);
        end
        @(posedge clk);
        #2;
        cmp_en = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_output("rel_credit", 64'(credit_cnt), 64'h8888);
        check_output("rel_pvalid", 64'(pvalid), 64'd0);
        check_output("rel_err", 64'(credit_err), 64'd0);
        check_output("rel_flow_tready", 64'(flow_tready), 64'd1);
        check_output("rel_d3_credit", 64'(d3_credit_cnt), 64'h888);
        check_output("rel_d3_err", 64'(d3_credit_err), 64'd0);

        // Channel 0 alone: credit runs dry after 8 beats, 2 returns buy 2 more.
        beats = 0; ids.delete();
        ch_tvalid = 4'b0001;
        repeat (10) tick();
        check_output("ch0_beats", 64'(beats), 64'd8);
        check_output("ch0_credit", 64'(credit_cnt[3:0]), 64'd0);
        check_output("ch0_tready_dry", 64'(ch_tready[0]), 64'd0);
        flow_tvalid = 1'b1; flow_tdata = 2'd0;
        d3_flow_tvalid = 1'b1; d3_flow_tdata = 2'd3;
        tick();
        d3_flow_tvalid = 1'b0;
        tick();
        flow_tvalid = 1'b0;
        repeat (4) tick();
        check_output("ch0_beats_refill", 64'(beats), 64'd10);
        foreach (ids[i]) check_output("ch0_id", 64'(ids[i]), 64'd0);
        check_output("d3_bad_id_credit", 64'(d3_credit_cnt), 64'h888);
        check_output("d3_bad_id_err", 64'(d3_credit_err), 64'd1);
        ch_tvalid = '0;
        pulse_reset();

        // All channels at full credit: strict rotation, one beat per cycle.
        beats = 0; ids.delete();
        ch_tvalid = 4'hF;
        repeat (8) tick();
        ch_tvalid = '0;
        repeat (2) tick();
        check_output("rr_beats", 64'(beats), 64'd8);
        check_rr_ids("rr_id", 8);
        check_output("rr_credit", 64'(credit_cnt), 64'h6666);

        // Output stall for 5 cycles mid-stream.
        beats = 0; ids.delete();
        ch_tvalid = 4'hF;
        repeat (3) tick();
        p_tready = 1'b0;
        repeat (5) begin
            tick();
            check_output("stall_tready", 64'(ch_tready), 64'd0);
            check_output("stall_pvalid", 64'(pvalid), 64'd1);
        end
        p_tready = 1'b1;
        repeat (4) tick();
        ch_tvalid = '0;
        repeat (2) tick();
        check_rr_ids("stall_id", 7);
        check_output("stall_credit", 64'(credit_cnt), 64'h5444);

        // Reset while a beat is held on the output.
        p_tready = 1'b0;
        ch_tvalid = 4'hF;
        repeat (2) tick();
        check_output("held_pvalid", 64'(pvalid), 64'd1);
        pulse_reset();
        ch_tvalid = '0;
        p_tready = 1'b1;

        // Channel 2 at credit 3 granted in the same cycle as its own return.
        ch_tvalid = 4'b0100;
        repeat (5) tick();
        ch_tvalid = '0;
        tick();
        check_output("ch2_credit_pre", 64'(credit_cnt[11:8]), 64'd3);
        ch_tvalid = 4'b0100;
        flow_tvalid = 1'b1; flow_tdata = 2'd2;
        tick();
        ch_tvalid = '0;
        flow_tvalid = 1'b0;
        tick();
        check_output("ch2_credit_net0", 64'(credit_cnt[11:8]), 64'd3);
        check_output("ch2_err", 64'(credit_err), 64'd0);

        // Return to a full channel: dropped, error is sticky.
        flow_tvalid = 1'b1; flow_tdata = 2'd1;
        tick();
        flow_tvalid = 1'b0;
        check_output("ovf_credit", 64'(credit_cnt[7:4]), 64'd8);
        check_output("ovf_err", 64'(credit_err), 64'd1);
        repeat (3) tick();
        check_output("ovf_err_sticky", 64'(credit_err), 64'd1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
